// File: rtl/mem_slave_if.sv
// mem_if: valid/ready request channel between a CPU memory port and a memory responder.
// The master holds a request until ready; rdata is valid in the ready cycle.
interface mem_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_slave.sv
// mem_slave: word-organised synchronous RAM behind mem_if with byte strobes and WAIT_CYCLES wait states.
// Optional out-of-range detection (err, 32'hDEAD_BEEF reads, dropped writes) under MEM_SLAVE_RANGE_CHK_EN.
module mem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  mem_if.slave bus,
  output logic err
);
  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;
  logic             oor_reg;
  logic             ready_reg;
  logic             accept;
  logic             commit;
  logic             in_oor;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic             req_oor;
  logic [31:0]      rdata_word;
  logic             addr_unused;

`ifdef MEM_SLAVE_RANGE_CHK_EN
  logic err_reg;
  assign in_oor      = |bus.addr[31:IDX_W+2];
  assign addr_unused = ^bus.addr[1:0];
`else
  assign in_oor      = 1'b0;
  assign addr_unused = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // commit marks the edge that enters RESP: memory write and read capture both happen there
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = RESP;
            commit     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      oor_reg   <= 1'b0;
    end else if (accept) begin
      idx_reg   <= bus.addr[IDX_W+1:2];
      wdata_reg <= bus.wdata;
      wstrb_reg <= bus.wstrb;
      oor_reg   <= in_oor;
    end
  end

  // With zero wait states the commit edge is the acceptance edge, so the live request is used
  assign req_idx   = (state_reg == IDLE) ? bus.addr[IDX_W+1:2] : idx_reg;
  assign req_wdata = (state_reg == IDLE) ? bus.wdata : wdata_reg;
  assign req_wstrb = (state_reg == IDLE) ? bus.wstrb : wstrb_reg;
  assign req_oor   = (state_reg == IDLE) ? in_oor : oor_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= commit;
    end
  end

`ifdef MEM_SLAVE_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= commit && req_oor;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (commit && req_wstrb[gi] && !req_oor) begin
          ram[req_idx] <= req_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_byte_reg <= '0;
        end else if (commit && (req_wstrb == 4'd0)) begin
          rd_byte_reg <= req_oor ? BAD_WORD[8*gi +: 8] : ram[req_idx];
        end
      end

      assign rdata_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  assign bus.ready = ready_reg;
  assign bus.rdata = rdata_word;
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: three mem_slave instances (0, 1 and 3 wait states) driven with directed and
// $urandom transactions, checked against a byte-addressed reference memory.
module tb_mem_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_if bus_w0 ();
  mem_if bus_w1 ();
  mem_if bus_w3 ();

  logic [2:0]  valid_v = '0;
  logic [2:0]  ready_v;
  logic [2:0]  err_v;
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [3:0]  wstrb_v [3];
  logic [31:0] rdata_v [3];
  int          wait_of [3] = '{0, 1, 3};

  assign bus_w0.valid = valid_v[0];
  assign bus_w0.addr  = addr_v[0];
  assign bus_w0.wdata = wdata_v[0];
  assign bus_w0.wstrb = wstrb_v[0];
  assign ready_v[0]   = bus_w0.ready;
  assign rdata_v[0]   = bus_w0.rdata;
  assign bus_w1.valid = valid_v[1];
  assign bus_w1.addr  = addr_v[1];
  assign bus_w1.wdata = wdata_v[1];
  assign bus_w1.wstrb = wstrb_v[1];
  assign ready_v[1]   = bus_w1.ready;
  assign rdata_v[1]   = bus_w1.rdata;
  assign bus_w3.valid = valid_v[2];
  assign bus_w3.addr  = addr_v[2];
  assign bus_w3.wdata = wdata_v[2];
  assign bus_w3.wstrb = wstrb_v[2];
  assign ready_v[2]   = bus_w3.ready;
  assign rdata_v[2]   = bus_w3.rdata;

  mem_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .rst_n(rst_n), .bus(bus_w0), .err(err_v[0]));
  mem_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1), .err(err_v[1]));
  mem_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut_w3 (.clk(clk), .rst_n(rst_n), .bus(bus_w3), .err(err_v[2]));

  // Reference: byte-addressed 4 KiB memory per instance, with per-byte "known" flags
  logic [7:0]  ref_mem   [3][4096];
  bit          ref_known [3][4096];
  logic [31:0] last_rd   [3];
  logic [31:0] last_mask [3];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_oor(input logic [31:0] a);
`ifdef MEM_SLAVE_RANGE_CHK_EN
    return a[31:12] != 20'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input string tag, output int rdy_cyc);
    logic [31:0] exp_rd, mask, got_rd;
    logic        got_err;
    bit          oor;
    int          lat, base;
    oor  = addr_oor(a);
    base = int'(a & 32'h0000_0FFC);
    exp_rd = '0;
    mask   = '0;
    if (s == 4'd0) begin
      if (oor) begin
        exp_rd = 32'hDEAD_BEEF;
        mask   = '1;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ref_known[k][base+b]) begin
            exp_rd[8*b +: 8] = ref_mem[k][base+b];
            mask[8*b +: 8]   = 8'hFF;
          end
        end
      end
    end
    valid_v[k] = 1'b1;
    addr_v[k]  = a;
    wdata_v[k] = d;
    wstrb_v[k] = s;
    lat = 0;
    rdy_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ready_v[k]) begin
        lat = c;
        rdy_cyc = cyc;
        break;
      end
      // After acceptance only latched fields may matter; valid may even drop
      addr_v[k]  = $urandom;
      wdata_v[k] = $urandom;
      wstrb_v[k] = 4'($urandom);
      valid_v[k] = 1'($urandom_range(0, 1));
    end
    got_rd  = rdata_v[k];
    got_err = err_v[k];
    valid_v[k] = 1'b0;
    addr_v[k]  = $urandom;
    wstrb_v[k] = 4'($urandom);
    check($sformatf("%s latency", tag), 32'(lat), 32'(1 + wait_of[k]));
    check($sformatf("%s err", tag), 32'(got_err), 32'(oor));
    if (s == 4'd0) begin
      if (mask != 0) check($sformatf("%s rdata", tag), got_rd & mask, exp_rd & mask);
      last_rd[k]   = exp_rd;
      last_mask[k] = mask;
    end else begin
      if (last_mask[k] != 0) check($sformatf("%s rdata_hold", tag), got_rd & last_mask[k], last_rd[k] & last_mask[k]);
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            ref_mem[k][base+b]   = d[8*b +: 8];
            ref_known[k][base+b] = 1'b1;
          end
        end
      end
    end
    $display("txn w%0d %-10s addr=%08h wdata=%08h wstrb=%h rdata=%08h err=%0d lat=%0d",
             wait_of[k], tag, a, d, s, got_rd, got_err, lat);
    @(posedge clk);
    #1;
    check($sformatf("%s ready_pulse", tag), 32'(ready_v[k]), 32'd0);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input string tag);
    int rc;
    txn(k, a, 32'h0, 4'h0, tag, rc);
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    int rc;
    txn(k, a, d, s, tag, rc);
  endtask

  task automatic reset_state_check();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst ready w%0d", wait_of[k]), 32'(ready_v[k]), 32'd0);
      check($sformatf("rst err w%0d", wait_of[k]), 32'(err_v[k]), 32'd0);
      check($sformatf("rst rdata w%0d", wait_of[k]), rdata_v[k], 32'h0);
      last_rd[k]   = '0;
      last_mask[k] = '1;
    end
  endtask

  initial begin
    int c0, c1, c2;
    logic [31:0] a;
    logic [3:0]  s;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = '0;
      wdata_v[k] = '0;
      wstrb_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_state_check();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      wr(k, 32'h000, 32'h0BAD_F00D, 4'hF, "init0");
      wr(k, 32'h004, 32'h1357_9BDF, 4'hF, "init4");
      wr(k, 32'h030, 32'hC0FF_EE00, 4'hF, "init30");
      wr(k, 32'h010, 32'hA5A5_1234, 4'hF, "full_wr");
      rd(k, 32'h010, "full_rd");
      wr(k, 32'h020, 32'hFFFF_FFFF, 4'hF, "strb_wr1");
      wr(k, 32'h020, 32'h0000_0000, 4'b0101, "strb_wr2");
      rd(k, 32'h020, "strb_rd");
      wr(k, 32'hFFC, 32'h5555_AAAA, 4'hF, "wrap_wr");
      rd(k, 32'hFFC, "wrap_rd");
      rd(k, 32'h000, "wrap_rd0");
      rd(k, 32'h0000_1004, "range_rd");
      wr(k, 32'h0004_2008, 32'h7777_8888, 4'hF, "range_wr");
      rd(k, 32'h008, "range_chk");
      // Three back-to-back reads: ready must repeat every 2+WAIT_CYCLES cycles
      txn(k, 32'h010, 32'h0, 4'h0, "b2b_a", c0);
      txn(k, 32'h020, 32'h0, 4'h0, "b2b_b", c1);
      txn(k, 32'h000, 32'h0, 4'h0, "b2b_c", c2);
      check("b2b period1", 32'(c1 - c0), 32'(2 + wait_of[k]));
      check("b2b period2", 32'(c2 - c1), 32'(2 + wait_of[k]));
      for (int i = 0; i < 40; i++) begin
        a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0,
             ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(1016, 1023)),
             2'($urandom)};
        s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        if (s == 4'h0) rd(k, a, "rand_rd");
        else wr(k, a, $urandom, s, "rand_wr");
      end
    end

    // Reset in cycle 2 of a 3-wait-state write: no ready, no commit
    wr(2, 32'h030, 32'hC0FF_EE00, 4'hF, "pre_rst");
    valid_v[2] = 1'b1;
    addr_v[2]  = 32'h030;
    wdata_v[2] = 32'h1111_1111;
    wstrb_v[2] = 4'hF;
    @(posedge clk);
    #1;
    check("midrst ready c1", 32'(ready_v[2]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid_v[2] = 1'b0;
    #1;
    check("midrst ready async", 32'(ready_v[2]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midrst ready held", 32'(ready_v[2]), 32'd0);
    end
    reset_state_check();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("midrst no_ready", 32'(ready_v[2]), 32'd0);
    end
    $display("txn w3 mid_reset  addr=00000030 write aborted by reset in cycle 2");
    rd(2, 32'h030, "post_rst");
    rd(1, 32'h010, "post_rst");
    rd(0, 32'hFFC, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
